// File: rtl/ahfp_add_sub.sv
// ahfp_add_sub: IEEE-754 binary32 adder, result = round_rne(dataa + datab),
// one register of latency. Denormal inputs are flushed to zero and
// underflowing results become signed zero; NaN results are the canonical
// quiet NaN 7FC00000.
module ahfp_add_sub (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Leading-zero count of a 27-bit significand with guard/round/sticky.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Round to nearest, ties to even. The input is {sig[23:0], g, r, s}.
  // Bit 24 of the return value is the rounding carry.
  function automatic logic [24:0] round_rne(input logic [26:0] m);
    logic up;
    up = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[26:3]} + {24'd0, up};
  endfunction

  // Stage p0: unpack and classify the operands.
  logic        sa_p0, sb_p0;
  logic [7:0]  ea_p0, eb_p0;
  logic [22:0] fa_p0, fb_p0;
  logic        nan_a_p0, nan_b_p0, inf_a_p0, inf_b_p0, zero_a_p0, zero_b_p0;

  assign sa_p0     = dataa[31];
  assign sb_p0     = datab[31];
  assign ea_p0     = dataa[30:23];
  assign eb_p0     = datab[30:23];
  assign fa_p0     = dataa[22:0];
  assign fb_p0     = datab[22:0];
  assign nan_a_p0  = (ea_p0 == 8'hFF) && (fa_p0 != 23'd0);
  assign nan_b_p0  = (eb_p0 == 8'hFF) && (fb_p0 != 23'd0);
  assign inf_a_p0  = (ea_p0 == 8'hFF) && (fa_p0 == 23'd0);
  assign inf_b_p0  = (eb_p0 == 8'hFF) && (fb_p0 == 23'd0);
  // Exponent zero covers both true zero and denormals (flushed).
  assign zero_a_p0 = (ea_p0 == 8'h00);
  assign zero_b_p0 = (eb_p0 == 8'h00);

  // Order by magnitude: exponent first, then fraction.
  logic        a_big_p0;
  logic        s_big_p0;
  logic [7:0]  e_big_p0, e_small_p0, ediff_p0;
  logic [22:0] f_big_p0, f_small_p0;
  logic        eff_sub_p0;

  assign a_big_p0   = {ea_p0, fa_p0} >= {eb_p0, fb_p0};
  assign s_big_p0   = a_big_p0 ? sa_p0 : sb_p0;
  assign e_big_p0   = a_big_p0 ? ea_p0 : eb_p0;
  assign e_small_p0 = a_big_p0 ? eb_p0 : ea_p0;
  assign f_big_p0   = a_big_p0 ? fa_p0 : fb_p0;
  assign f_small_p0 = a_big_p0 ? fb_p0 : fa_p0;
  assign ediff_p0   = e_big_p0 - e_small_p0;
  assign eff_sub_p0 = sa_p0 ^ sb_p0;

  // Alignment: the small significand is shifted into a 26-bit window
  // (24 significand bits + guard + round); whatever falls below that window
  // collapses into the sticky bit. Past 25 positions only sticky survives.
  logic [49:0] shifted_p0;
  logic [26:0] big_ext_p0, small_ext_p0;

  assign shifted_p0   = {1'b1, f_small_p0, 26'd0} >> ediff_p0;
  assign big_ext_p0   = {1'b1, f_big_p0, 3'b000};
  assign small_ext_p0 = (ediff_p0 >= 8'd26) ? 27'd1
                                            : {shifted_p0[49:24], |shifted_p0[23:0]};

  logic [27:0]        sum_p0;
  logic [26:0]        dif_p0;
  logic [26:0]        norm_p0;
  logic [4:0]         lz_p0;
  logic signed [9:0]  exp_n_p0;
  logic               cancel_p0;

  // Add or subtract the aligned significands and renormalize so bit 26 is the leading one.
  always_comb begin
    sum_p0    = {1'b0, big_ext_p0} + {1'b0, small_ext_p0};
    dif_p0    = big_ext_p0 - small_ext_p0;
    norm_p0   = 27'd0;
    lz_p0     = 5'd0;
    exp_n_p0  = 10'sd0;
    cancel_p0 = 1'b0;
    if (!eff_sub_p0) begin
      if (sum_p0[27]) begin
        norm_p0  = {sum_p0[27:2], sum_p0[1] | sum_p0[0]};
        exp_n_p0 = signed'({2'b00, e_big_p0}) + 10'sd1;
      end else begin
        norm_p0  = sum_p0[26:0];
        exp_n_p0 = signed'({2'b00, e_big_p0});
      end
    end else begin
      if (dif_p0 == 27'd0) begin
        cancel_p0 = 1'b1;
      end else begin
        lz_p0    = lzc27(dif_p0);
        norm_p0  = dif_p0 << lz_p0;
        exp_n_p0 = signed'({2'b00, e_big_p0}) - signed'({5'd0, lz_p0});
      end
    end
  end

  logic [24:0]       rnd_p0;
  logic [23:0]       mant_p0;
  logic signed [9:0] exp_r_p0;

  // Round, then absorb a rounding carry by bumping the exponent.
  always_comb begin
    rnd_p0 = round_rne(norm_p0);
    if (rnd_p0[24]) begin
      mant_p0  = rnd_p0[24:1];
      exp_r_p0 = exp_n_p0 + 10'sd1;
    end else begin
      mant_p0  = rnd_p0[23:0];
      exp_r_p0 = exp_n_p0;
    end
  end

  logic [31:0] next_p0;

  // Special-case priority ahead of the ordinary packed result.
  always_comb begin
    next_p0 = {s_big_p0, exp_r_p0[7:0], mant_p0[22:0]};
    if (nan_a_p0 || nan_b_p0)
      next_p0 = QNAN;
    else if (inf_a_p0 && inf_b_p0 && (sa_p0 != sb_p0))
      next_p0 = QNAN;
    else if (inf_a_p0)
      next_p0 = {sa_p0, 8'hFF, 23'd0};
    else if (inf_b_p0)
      next_p0 = {sb_p0, 8'hFF, 23'd0};
    else if (zero_a_p0 && zero_b_p0)
      next_p0 = {sa_p0 & sb_p0, 31'd0};
    else if (zero_a_p0)
      next_p0 = datab;
    else if (zero_b_p0)
      next_p0 = dataa;
    else if (cancel_p0)
      next_p0 = 32'h00000000;
    else if (exp_r_p0 >= 10'sd255)
      next_p0 = {s_big_p0, 8'hFF, 23'd0};
    else if (exp_r_p0 <= 10'sd0)
      next_p0 = {s_big_p0, 31'd0};
  end

  // Stage p1: output register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) result <= 32'h00000000;
    else       result <= next_p0;
  end

endmodule

// File: tb/tb_ahfp_add_sub.sv
// Bench for ahfp_add_sub: expected sums are queued when operands are driven
// and popped when the registered result appears one cycle later.
module tb_ahfp_add_sub;

  logic        clk;
  logic        reset;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];

  ahfp_add_sub dut (
    .clk    (clk),
    .reset  (reset),
    .dataa  (dataa),
    .datab  (datab),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation on the falling edge and queue its expected sum.
  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    dataa = a;
    datab = b;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset = 1'b1;
    dataa = 32'h3F800000;
    datab = 32'h40000000;
    #2;
    tests_run++;
    if (result !== 32'h00000000) begin
      tests_failed++;
      $display("FAIL reset_async: result=%h want=%h", result, 32'h00000000);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (result !== 32'h00000000) begin
      tests_failed++;
      $display("FAIL reset_hold: result=%h want=%h", result, 32'h00000000);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'h40400000);
    @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL reset_release: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (result !== e) begin
        tests_failed++;
        $display("FAIL reset_release: result=%h want=%h", result, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[4] = '{32'h00000000, 32'h3F800000, 32'hC0000000, 32'h40400000};
    logic [31:0] b[4] = '{32'h00000000, 32'h40000000, 32'h40800000, 32'h40600000};
    logic [31:0] r[4] = '{32'h00000000, 32'h40400000, 32'h40000000, 32'h40D00000};
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      push_op(a[i], b[i], r[i]);
      @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          tests_failed++;
          $display("FAIL b2b[%0d]: %h+%h result=%h want=%h", i, a[i], b[i], result, e);
        end
      end
    end
  endtask

  task automatic test_align_round();
    logic [31:0] a[3] = '{32'h43FA0000, 32'h46A5E51F, 32'h3F8E363B};
    logic [31:0] b[3] = '{32'hC1133333, 32'hC35FAB85, 32'h3AA137FA};
    logic [31:0] r[3] = '{32'h43F56666, 32'h46A425C8, 32'h3F8E5E89};
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      push_op(a[i], b[i], r[i]);
      @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL align[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          tests_failed++;
          $display("FAIL align[%0d]: %h+%h result=%h want=%h", i, a[i], b[i], result, e);
        end
      end
    end
  endtask

  task automatic test_normalize();
    logic [31:0] a[4] = '{32'hC2FF999A, 32'h41EC0000, 32'hC640E400, 32'h40400000};
    logic [31:0] b[4] = '{32'h42FCCCCD, 32'h453BF800, 32'hC7F12040, 32'hC0400000};
    logic [31:0] r[4] = '{32'hBFB33340, 32'h453DD000, 32'hC8049E60, 32'h00000000};
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      push_op(a[i], b[i], r[i]);
      @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL norm[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          tests_failed++;
          $display("FAIL norm[%0d]: %h+%h result=%h want=%h", i, a[i], b[i], result, e);
        end
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] a[7] = '{32'h7F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h00000001,
                          32'h80000000, 32'h7FC12345, 32'h00000000};
    logic [31:0] b[7] = '{32'hFF800000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000,
                          32'h80000000, 32'h3F800000, 32'h80000000};
    logic [31:0] r[7] = '{32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'h3F800000,
                          32'h80000000, 32'h7FC00000, 32'h00000000};
    logic [31:0] e;
    for (int i = 0; i < 7; i++) begin
      push_op(a[i], b[i], r[i]);
      @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL special[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          tests_failed++;
          $display("FAIL special[%0d]: %h+%h result=%h want=%h", i, a[i], b[i], result, e);
        end
      end
    end
  endtask

  task automatic test_tie();
    logic [31:0] a[2] = '{32'h4B800000, 32'h4B800001};
    logic [31:0] b[2] = '{32'h3F800000, 32'h3F800000};
    logic [31:0] r[2] = '{32'h4B800000, 32'h4B800002};
    logic [31:0] e;
    for (int i = 0; i < 2; i++) begin
      push_op(a[i], b[i], r[i]);
      @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL tie[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          tests_failed++;
          $display("FAIL tie[%0d]: %h+%h result=%h want=%h", i, a[i], b[i], result, e);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] e;
    push_op(32'h3F800000, 32'h40000000, 32'h40400000);
    @(posedge clk);
    #1;
    tests_run++;
    e = exp_q.pop_front();
    if (result !== e) begin
      tests_failed++;
      $display("FAIL mid_pre: result=%h want=%h", result, e);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (result !== 32'h00000000) begin
      tests_failed++;
      $display("FAIL mid_async: result=%h want=%h", result, 32'h00000000);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (result !== 32'h00000000) begin
      tests_failed++;
      $display("FAIL mid_hold: result=%h want=%h", result, 32'h00000000);
    end
    @(negedge clk);
    reset = 1'b0;
    dataa = 32'h40400000;
    datab = 32'h40600000;
    exp_q.push_back(32'h40D00000);
    @(posedge clk);
    #1;
    tests_run++;
    e = exp_q.pop_front();
    if (result !== e) begin
      tests_failed++;
      $display("FAIL mid_release: result=%h want=%h", result, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_align_round();
    test_normalize();
    test_special();
    test_tie();
    test_reset_midstream();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: left=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
